// File: rtl/or1200_vlx_ctrl.sv
// VLX store-unit sequencer: packs variable-length codes MSB-first into a bit buffer and hands
// whole bytes to or1200_vlx_su one at a time, with 0xFF byte stuffing and 1-padding on flush.
module or1200_vlx_ctrl #(
   parameter int BUF_W    = 32,
   parameter int MAX_LEN  = 16,
   parameter bit STUFF_EN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        vlx_valid_i,
   input  logic [31:0] vlx_dat_i,
   input  logic [4:0]  vlx_len_i,
   input  logic        flush_i,
   input  logic        set_addr_i,
   output logic        ready_o,
   output logic        flush_done_o,
   output logic        su_init_o,
   output logic        su_store_o,
   output logic [31:0] su_dat_o,
   input  logic        su_ack_i,
   output logic [5:0]  fill_o,
   output logic [15:0] byte_cnt_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;
   typedef logic [BUF_W-1:0] bits_t;

   localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);
   localparam logic [5:0] BUF_W_C   = 6'(BUF_W);
   localparam logic [5:0] ROOM_C    = 6'(BUF_W - MAX_LEN);

   state_t      state_q, state_d;
   bits_t       bits_q, bits_d;
   logic [5:0]  fill_q, fill_d;
   logic        flush_pend_q, flush_pend_d;
   logic [7:0]  byte_q, byte_d;
   logic [15:0] cnt_q, cnt_d;
   logic        init_q, init_d;
   logic [31:0] addr_q, addr_d;
   logic        done_q, done_d;

   logic [5:0]  len_c;
   logic        do_addr, do_flush, do_code, extract;
   bits_t       base_bits, code_bits;
   logic [5:0]  base_fill;

   assign len_c    = ({1'b0, vlx_len_i} > MAX_LEN_C) ? MAX_LEN_C : {1'b0, vlx_len_i};
   assign ready_o  = (state_q == IDLE) && !flush_pend_q && (fill_q <= ROOM_C);
   assign do_addr  = ready_o && set_addr_i;
   assign do_flush = ready_o && !set_addr_i && flush_i;
   assign do_code  = ready_o && !set_addr_i && !flush_i && vlx_valid_i;
   // A set_addr clears the buffer, so it also cancels any extraction in the same cycle.
   assign extract  = (state_q == IDLE) && (fill_q >= 6'd8) && !do_addr;
   assign code_bits = bits_t'(vlx_dat_i) & ((bits_t'(1) << len_c) - bits_t'(1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         bits_q       <= '0;
         fill_q       <= '0;
         flush_pend_q <= 1'b0;
         byte_q       <= '0;
         cnt_q        <= '0;
         init_q       <= 1'b0;
         addr_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bits_q       <= bits_d;
         fill_q       <= fill_d;
         flush_pend_q <= flush_pend_d;
         byte_q       <= byte_d;
         cnt_q        <= cnt_d;
         init_q       <= init_d;
         addr_q       <= addr_d;
         done_q       <= done_d;
      end
   end

   // NOTE: every variable gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      byte_d       = byte_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      init_d       = 1'b0;
      done_d       = 1'b0;
      base_bits    = bits_q;
      base_fill    = fill_q;

      unique case (state_q)
         IDLE: begin
            if (extract) begin
               byte_d    = bits_q[BUF_W-1 -: 8];
               base_bits = bits_q << 8;
               base_fill = fill_q - 6'd8;
               state_d   = ISSUE;
            end else if (flush_pend_q && (fill_q != 6'd0)) begin
               // Bits below the fill are always zero, so OR-ing in the ones pads the byte.
               byte_d    = bits_q[BUF_W-1 -: 8] | (8'hFF >> fill_q);
               base_bits = '0;
               base_fill = '0;
               state_d   = ISSUE;
            end else if (flush_pend_q) begin
               flush_pend_d = 1'b0;
               done_d       = 1'b1;
            end
         end
         ISSUE: begin
            cnt_d   = cnt_q + 16'd1;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (su_ack_i) begin
               if (STUFF_EN && (byte_q == 8'hFF)) begin
                  byte_d  = 8'h00;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      bits_d = base_bits;
      fill_d = base_fill;
      // New bits land just below whatever remains after this cycle's extraction.
      if (do_code) begin
         bits_d = base_bits | (code_bits << (BUF_W_C - base_fill - len_c));
         fill_d = base_fill + len_c;
      end
      if (do_flush) flush_pend_d = 1'b1;
      if (do_addr) begin
         init_d = 1'b1;
         addr_d = vlx_dat_i;
         bits_d = '0;
         fill_d = '0;
         cnt_d  = '0;
      end
   end

   always_comb begin
      su_store_o   = (state_q == ISSUE);
      su_init_o    = init_q;
      su_dat_o     = init_q ? addr_q : {24'b0, byte_q};
      flush_done_o = done_q;
      fill_o       = fill_q;
      byte_cnt_o   = cnt_q;
   end

endmodule

// File: tb/tb_or1200_vlx_ctrl.sv
// Scoreboard bench for or1200_vlx_ctrl: directed codes push expected bytes/addresses, a monitor
// pops and compares on every su_store_o / su_init_o, and an auto-responder returns su_ack_i.
module tb_or1200_vlx_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vlx_valid = 1'b0;
   logic [31:0] vlx_dat = '0;
   logic [4:0]  vlx_len = '0;
   logic        flush = 1'b0;
   logic        set_addr = 1'b0;
   logic        su_ack = 1'b0;
   logic        ready, flush_done, su_init, su_store;
   logic [31:0] su_dat;
   logic [5:0]  fill;
   logic [15:0] byte_cnt;

   int vectors = 0;
   int miscompares = 0;
   bit ack_en = 1'b1;
   logic [7:0]  exp_bytes[$];
   logic [31:0] exp_addrs[$];

   or1200_vlx_ctrl dut (
      .clk_i(clk), .rst_i(rst), .vlx_valid_i(vlx_valid), .vlx_dat_i(vlx_dat),
      .vlx_len_i(vlx_len), .flush_i(flush), .set_addr_i(set_addr), .ready_o(ready),
      .flush_done_o(flush_done), .su_init_o(su_init), .su_store_o(su_store),
      .su_dat_o(su_dat), .su_ack_i(su_ack), .fill_o(fill), .byte_cnt_o(byte_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every presented store / init against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (su_store) begin
            if (exp_bytes.size() == 0) check("store_unexpected", {31'b0, su_store}, 32'd0);
            else check("store_byte", su_dat, {24'b0, exp_bytes.pop_front()});
         end
         if (su_init) begin
            if (exp_addrs.size() == 0) check("init_unexpected", {31'b0, su_init}, 32'd0);
            else check("init_addr", su_dat, exp_addrs.pop_front());
         end
      end
   end

   // Bus model: ack two cycles after each store pulse.
   initial begin
      forever begin
         @(posedge clk);
         if (ack_en && su_store) begin
            repeat (2) @(posedge clk);
            #1 su_ack = 1'b1;
            @(posedge clk);
            #1 su_ack = 1'b0;
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic [4:0] l, input bit v, input bit f,
                       input bit s);
      int n = 0;
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_send", {31'b0, ready}, 32'd1);
      vlx_dat = d; vlx_len = l; vlx_valid = v; flush = f; set_addr = s;
      @(posedge clk);
      #1;
      vlx_valid = 1'b0; flush = 1'b0; set_addr = 1'b0; vlx_dat = '0; vlx_len = '0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_bytes.size() != 0 || !ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", exp_bytes.size(), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_flush_done();
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 500) begin
         @(negedge clk);
         seen = flush_done;
         n++;
      end
      check("flush_done_pulse", {31'b0, seen}, 32'd1);
      @(negedge clk);
      check("flush_done_one_cycle", {31'b0, flush_done}, 32'd0);
   endtask

   initial begin
      int n;
      #12;
      check("rst_store", {31'b0, su_store}, 32'd0);
      check("rst_dat", su_dat, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_fill", {26'b0, fill}, 32'd0);
      check("rst_cnt", {16'b0, byte_cnt}, 32'd0);

      // Initial address
      exp_addrs.push_back(32'h0000_1000);
      send(32'h1000, 5'd0, 1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      check("addr_cnt", {16'b0, byte_cnt}, 32'd0);

      // 101 + 11111 -> 0xBF
      exp_bytes.push_back(8'hBF);
      send(32'b101, 5'd3, 1'b1, 1'b0, 1'b0);
      send(32'b11111, 5'd5, 1'b1, 1'b0, 1'b0);
      drain();
      check("bf_ready", {31'b0, ready}, 32'd1);
      check("bf_cnt", {16'b0, byte_cnt}, 32'd1);
      check("bf_fill", {26'b0, fill}, 32'd0);

      // 0xFF is followed by a stuffed 0x00, both counted
      exp_addrs.push_back(32'h0000_2000);
      send(32'h2000, 5'd0, 1'b0, 1'b0, 1'b1);
      exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'h00);
      send(32'hFF, 5'd8, 1'b1, 1'b0, 1'b0);
      drain();
      check("stuff_cnt", {16'b0, byte_cnt}, 32'd2);

      // len=0 changes nothing
      send(32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("len0_fill", {26'b0, fill}, 32'd0);

      // Flush pads with ones: 0 + 1111111 = 0x7F
      exp_bytes.push_back(8'h7F);
      send(32'b0, 5'd1, 1'b1, 1'b0, 1'b0);
      send(32'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      wait_flush_done();
      check("flush_fill", {26'b0, fill}, 32'd0);
      check("flush_cnt", {16'b0, byte_cnt}, 32'd3);

      // Flush of a single 1 gives 0xFF, which is then stuffed
      exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'h00);
      send(32'b1, 5'd1, 1'b1, 1'b0, 1'b0);
      send(32'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      wait_flush_done();
      check("flush_ff_fill", {26'b0, fill}, 32'd0);

      // Back-to-back 16-bit codes; upper garbage bits ignored
      exp_bytes.push_back(8'hAB);
      exp_bytes.push_back(8'hCD);
      exp_bytes.push_back(8'h12);
      exp_bytes.push_back(8'h34);
      send(32'hFFFF_ABCD, 5'd16, 1'b1, 1'b0, 1'b0);
      send(32'h5555_1234, 5'd16, 1'b1, 1'b0, 1'b0);
      check("b2b_ready_low", {31'b0, ready}, 32'd0);
      check("b2b_fill", {26'b0, fill}, 32'd24);
      drain();

      // Length above MAX_LEN is clamped to 16: sixteen ones -> FF 00 FF 00
      exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'hFF);
      exp_bytes.push_back(8'h00);
      send(32'hFFFF_FFFF, 5'd20, 1'b1, 1'b0, 1'b0);
      drain();
      check("clamp_fill", {26'b0, fill}, 32'd0);

      // Reset during WAIT_ACK abandons the byte; a stale ack must not cause a store
      ack_en = 1'b0;
      exp_bytes.push_back(8'h3C);
      send(32'h3C, 5'd8, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (!su_store && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_store_seen", {31'b0, su_store}, 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_store", {31'b0, su_store}, 32'd0);
      check("midrst_init", {31'b0, su_init}, 32'd0);
      check("midrst_dat", su_dat, 32'd0);
      check("midrst_fill", {26'b0, fill}, 32'd0);
      check("midrst_cnt", {16'b0, byte_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      su_ack = 1'b1;
      @(negedge clk);
      su_ack = 1'b0;
      repeat (5) @(negedge clk);
      ack_en = 1'b1;
      exp_bytes.push_back(8'h5A);
      send(32'h5A, 5'd8, 1'b1, 1'b0, 1'b0);
      drain();
      check("post_rst_cnt", {16'b0, byte_cnt}, 32'd1);
      check("post_rst_fill", {26'b0, fill}, 32'd0);

      check("addr_queue_empty", exp_addrs.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
